// File: rtl/alu_operand_stager.sv
// Operand FIFO plus registered result stage wrapped around a combinational ALU core.
// Optional OP_COUNT_EN adds a 16-bit counter of delivered results on port op_count.
module alu_operand_stager #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
`ifdef OP_COUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  // DEPTH is a power of two, so "full" is just the top count bit set.
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic {R_EMPTY, R_FULL} rstate_t;

  logic [DEPTH-1:0][WIDTH-1:0] mem_a, mem_b;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  rstate_t                     rstate;
  logic                        fifo_empty, push, load;

  assign fifo_empty = (count == '0);
  assign in_ready   = (count != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign res_valid  = (rstate == R_FULL);
  assign load       = !fifo_empty && (!res_valid || res_ready);

  // Head is gated to zero when empty so the ALU sees a quiet input.
  assign alu_a = fifo_empty ? '0 : mem_a[rd_ptr];
  assign alu_b = fifo_empty ? '0 : mem_b[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate   <= R_EMPTY;
      res_data <= '0;
    end else begin
      case (rstate)
        R_EMPTY: begin
          if (load) begin
            res_data <= alu_out;
            rstate   <= R_FULL;
          end
        end
        R_FULL: begin
          if (load)           res_data <= alu_out;
          else if (res_ready) rstate   <= R_EMPTY;
        end
        default: rstate <= R_EMPTY;
      endcase
    end
  end

`ifdef OP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      op_count <= '0;
    else if (res_valid && res_ready) op_count <= op_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_operand_stager.sv
// Directed bench for alu_operand_stager; ALU stubbed as alu_out = alu_a + alu_b, scoreboard queue.
module tb_alu_operand_stager;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         res_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, res_valid;
  logic [W-1:0] alu_a, alu_b, alu_out, res_data;
`ifdef OP_COUNT_EN
  logic [15:0]  op_count;
`endif

  alu_operand_stager #(.WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
`ifdef OP_COUNT_EN
    .op_count(op_count),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  assign alu_out = alu_a + alu_b;
  always #5 clk = ~clk;

  int           errors = 0, checks = 0, npop = 0, s0 = 0;
  logic [W-1:0] exp_q[$];
  logic         hold = 1'b0;
  logic [W-1:0] hold_data = '0;
  bit           rr_rand = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: evaluated mid-cycle, describing the handshake at the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", W'(res_valid), 1);
        chk("hold_data", res_data, hold_data);
      end
      if (res_valid && res_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL spurious_result: observed=%0h expected=none", res_data);
        end
        if (exp_q.size() != 0) begin
          chk("result", res_data, exp_q.pop_front());
          npop++;
        end
      end
      hold      = res_valid && !res_ready;
      hold_data = res_data;
    end
  end

  always @(posedge clk) if (rr_rand) #1 res_ready = 1'($urandom_range(0, 1));

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Presents a pair until accepted; leaves in_valid high so sends can run back to back.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc = 1'b0;
    int t = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back(a + b);
      @(posedge clk); #1;
      t++;
    end
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL send_timeout: observed=not_accepted expected=accepted a=%0h b=%0h", a, b);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin cycles(1); t++; end
    chk("drain_left", W'(exp_q.size()), 0);
    cycles(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_res_valid", W'(res_valid), 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
`ifdef OP_COUNT_EN
    chk("rst_op_count", W'(op_count), 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    cycles(1);

    // Single op: latency two edges, then empty again
    res_ready = 1'b1;
    send(2, 2); idle();
    chk("single_alu_a_head", alu_a, 2);
    chk("single_not_yet_valid", W'(res_valid), 0);
    cycles(1);
    chk("single_valid", W'(res_valid), 1);
    chk("single_data", res_data, 4);
    chk("single_alu_a_empty", alu_a, 0);
    cycles(1);
    chk("single_done", W'(res_valid), 0);

    // Fill: one held result plus four queued; sixth pair must be refused
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(W'(i), W'(i));
    chk("fill_in_ready", W'(in_ready), 0);
    chk("fill_res_valid", W'(res_valid), 1);
    chk("fill_res_data", res_data, 2);
    in_a = 6; in_b = 6;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("full_refuse", W'(in_ready), 0);
      chk("full_stable", res_data, 2);
    end
    idle();
    res_ready = 1'b1;
    drain();
    cycles(2);
    chk("fill_no_extra", W'(res_valid), 0);

    // Streaming: one result per cycle
    s0 = npop;
    for (int i = 0; i < 16; i++) send(W'(i), W'(i));
    chk("stream_rate", W'(npop - s0), 14);
    idle();
    drain();
    cycles(2);

    // Random backpressure and random input gaps
    rr_rand = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send($urandom, $urandom);
      if ($urandom_range(0, 3) == 0) begin idle(); cycles(1); end
    end
    idle();
    rr_rand = 1'b0;
    cycles(2);
    res_ready = 1'b1;
    drain();
    cycles(2);

    // Modular wrap
    send(32'hFFFF_FFFF, 32'h1); idle();
    cycles(1);
    chk("wrap_valid", W'(res_valid), 1);
    chk("wrap_data", res_data, 0);
    drain();
    cycles(2);
`ifdef OP_COUNT_EN
    chk("op_count_total", W'(op_count), W'(npop));
`endif

    // Async reset with a held result and three queued pairs
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(W'(10 + i), W'(20));
    idle();
    chk("pre_rst_valid", W'(res_valid), 1);
    chk("pre_rst_full", W'(in_ready), 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_res_valid", W'(res_valid), 0);
    chk("arst_in_ready", W'(in_ready), 1);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_alu_b", alu_b, 0);
    chk("arst_res_data", res_data, 0);
`ifdef OP_COUNT_EN
    chk("arst_op_count", W'(op_count), 0);
`endif
    cycles(2);
    rst_n = 1'b1;
    res_ready = 1'b1;
    cycles(3);
    chk("post_rst_quiet", W'(res_valid), 0);
    chk("post_rst_alu_a", alu_a, 0);
    for (int i = 0; i < 3; i++) send(W'(7 + i), W'(100));
    idle();
    drain();
    cycles(2);
`ifdef OP_COUNT_EN
    chk("op_count_three", W'(op_count), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
